// File: rtl/stringreco_pkg.sv
// Shared types and constants for the string-recognizer sequencer.
package stringreco_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned CNT_W       = 14;
  localparam int unsigned DEB_SAMPLES = 3;
  localparam int unsigned IDX_W       = $clog2(WORD_W);

endpackage

// File: rtl/stringreco_seq_ctrl_btn_conditioner.sv
// Raw button -> 2-FF synchronizer -> strobe-sampled debounce -> one-cycle press pulse.
module btn_conditioner
  import stringreco_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic sample_i,
  output logic press_o
);

  localparam int unsigned DEB_W = $clog2(DEB_SAMPLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [DEB_W-1:0] deb_q, deb_d;

  // Level flips only after DEB_SAMPLES consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    deb_d   = deb_q;
    if (sample_i) begin
      if (sync2_q == level_q) begin
        deb_d = '0;
      end else if (deb_q == DEB_W'(DEB_SAMPLES - 1)) begin
        level_d = sync2_q;
        deb_d   = '0;
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      deb_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      deb_q   <= deb_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stringreco_seq_ctrl.sv
// Single-clock sequencer: button conditioning, tick-paced MSB-first bit streaming
// into the recognizer, and saturating match counting.
module stringreco_seq_ctrl
  import stringreco_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned SAMPLE_DIV = 100_000,
  parameter int unsigned COUNT_MAX  = 9999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_clr,
  input  logic              btn_run,
  input  logic [WORD_W-1:0] sw,
  input  logic              match,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              reco_clr,
  output logic [IDX_W-1:0]  bit_idx,
  output logic [CNT_W-1:0]  match_count,
  output logic [2:0]        state
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned SAMP_W = $clog2(SAMPLE_DIV);

  logic [SAMP_W-1:0] samp_q, samp_d;
  logic              sample_stb;
  logic              clr_press, run_press;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              tick_hit;
  logic              bit_out_q, bit_out_d;
  logic              valid_q, valid_d;
  logic              clr_q, clr_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Free-running debounce sample strobe shared by both buttons.
  assign sample_stb = (samp_q == SAMP_W'(SAMPLE_DIV - 1));
  assign samp_d     = sample_stb ? '0 : samp_q + SAMP_W'(1);

  btn_conditioner u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_i    (btn_clr),
    .sample_i (sample_stb),
    .press_o  (clr_press)
  );

  btn_conditioner u_run (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_i    (btn_run),
    .sample_i (sample_stb),
    .press_o  (run_press)
  );

  assign tick_hit = (tick_q == TICK_W'(TICK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    tick_d    = tick_q;
    bit_out_d = bit_out_q;
    valid_d   = 1'b0;
    clr_d     = 1'b0;
    pend_d    = valid_q;
    cnt_d     = cnt_q;

    // Match is only meaningful the cycle after a strobe.
    if (pend_q && match && (cnt_q != CNT_W'(COUNT_MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (clr_press) begin
      state_d = IDLE;
      shreg_d = '0;
      idx_d   = '0;
      tick_d  = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE:  if (run_press) state_d = LOAD;
        LOAD: begin
          shreg_d = sw;
          idx_d   = '0;
          tick_d  = '0;
          state_d = RUN;
        end
        RUN: begin
          // Strobe of the last bit is visible now; its match sample falls in DONE.
          if (valid_q && (idx_q == '0)) begin
            state_d = DONE;
          end else begin
            if (tick_hit) begin
              tick_d    = '0;
              bit_out_d = shreg_q[WORD_W-1];
              valid_d   = 1'b1;
              shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
              idx_d     = idx_q + IDX_W'(1);
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
            if (run_press && !(tick_hit && (idx_q == IDX_W'(WORD_W - 1)))) begin
              state_d = PAUSE;
            end
          end
        end
        PAUSE: if (run_press) state_d = RUN;
        DONE:  if (run_press) state_d = LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q    <= '0;
      state_q   <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      tick_q    <= '0;
      bit_out_q <= 1'b0;
      valid_q   <= 1'b0;
      clr_q     <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      samp_q    <= samp_d;
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      tick_q    <= tick_d;
      bit_out_q <= bit_out_d;
      valid_q   <= valid_d;
      clr_q     <= clr_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bit_out     = bit_out_q;
  assign bit_valid   = valid_q;
  assign reco_clr    = clr_q;
  assign bit_idx     = idx_q;
  assign match_count = cnt_q;
  assign state       = state_q;

endmodule
